// File: rtl/llc_set_loader_pkg.sv
// Shared LLC types for the set loader and the lookup stage it feeds.
// Holds set/tag/state/way types, cache constants and the lookup FIFO packet.
package llc_set_loader_pkg;

  localparam int LLC_WAYS       = 4;
  localparam int LLC_WAY_BITS   = 2;
  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_TAG_BITS   = 12;
  localparam int LLC_STATE_BITS = 3;

  typedef logic [LLC_SET_BITS-1:0] llc_set_t;
  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  typedef enum logic [LLC_STATE_BITS-1:0] {
    INVALID   = 3'd0,
    VALID     = 3'd1,
    SHARED    = 3'd2,
    EXCLUSIVE = 3'd3,
    MODIFIED  = 3'd4
  } llc_state_t;

  typedef llc_tag_t   [LLC_WAYS-1:0] llc_tag_arr_t;
  typedef llc_state_t [LLC_WAYS-1:0] llc_state_arr_t;

  typedef struct packed {
    llc_tag_t tag_input;
    llc_set_t set;
  } fifo_mem_lookup_packet;

  localparam llc_state_arr_t STATES_RST =
    llc_state_arr_t'('0);

  function automatic fifo_mem_lookup_packet
    mk_pkt(input llc_tag_t tag, input llc_set_t set);
    fifo_mem_lookup_packet p;
    p.tag_input = tag;
    p.set       = set;
    return p;
  endfunction

endpackage

// File: rtl/llc_set_buf_regs.sv
// Capture/hold register bank for one LLC set snapshot.
// Sync clear dominates load; otherwise contents are held.
module llc_set_buf_regs
  import llc_set_loader_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           ld,
  input  llc_tag_arr_t   tags_i,
  input  llc_state_arr_t states_i,
  input  llc_way_t       evict_i,
  output llc_tag_arr_t   tags_o,
  output llc_state_arr_t states_o,
  output llc_way_t       evict_o
);

  llc_tag_arr_t   tags_d, tags_q;
  llc_state_arr_t states_d, states_q;
  llc_way_t       evict_d, evict_q;

  always_comb begin
    tags_d   = tags_q;
    states_d = states_q;
    evict_d  = evict_q;
    if (clr) begin
      tags_d   = '0;
      states_d = STATES_RST;
      evict_d  = '0;
    end else if (ld) begin
      tags_d   = tags_i;
      states_d = states_i;
      evict_d  = evict_i;
    end
  end

  always_ff @(posedge clk) begin
    tags_q   <= tags_d;
    states_q <= states_d;
    evict_q  <= evict_d;
  end

  assign tags_o   = tags_q;
  assign states_o = states_q;
  assign evict_o  = evict_q;

endmodule

// File: rtl/llc_set_loader.sv
// LLC set loader: reads one set from tag/state SRAMs, snapshots it, feeds lookup.
// Optional same-set read skipping is enabled by defining LLC_SET_REUSE_EN.
module llc_set_loader
  import llc_set_loader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  llc_set_t              req_set,
  input  llc_tag_t              req_tag,
  output logic                  rd_en,
  output llc_set_t              rd_set,
  input  llc_tag_arr_t          rd_tags,
  input  llc_state_arr_t        rd_states,
  input  llc_way_t              rd_evict_way,
  output llc_tag_arr_t          tags_buf,
  output llc_state_arr_t        states_buf,
  output llc_way_t              evict_way_buf,
  input  logic                  fifo_full_lookup,
  output logic                  fifo_push_lookup,
  output fifo_mem_lookup_packet fifo_lookup_in,
  input  logic                  buf_release,
  input  logic                  set_wr,
  input  llc_set_t              set_wr_set
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PUSH = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  logic [1:0] state_d, state_q;
  logic [1:0] cnt_d, cnt_q;
  fifo_mem_lookup_packet pkt_d, pkt_q;
  logic buf_ld;
  logic hit;

`ifdef LLC_SET_REUSE_EN
  logic     reuse_vld_d, reuse_vld_q;
  logic     wr_seen_d, wr_seen_q;
  logic     set_wr_hit;
  llc_set_t cur_set;

  assign cur_set    = pkt_q.set;
  assign set_wr_hit = set_wr && (set_wr_set == cur_set);
  // a colliding write on the same cycle forces a real read
  assign hit = req_valid && reuse_vld_q &&
               !set_wr_hit && (req_set == cur_set);

  always_comb begin
    reuse_vld_d = reuse_vld_q && !set_wr_hit;
    wr_seen_d   = wr_seen_q || set_wr_hit;
    if (state_q == S_IDLE && req_valid) begin
      reuse_vld_d = 1'b0;
      wr_seen_d   = 1'b0;
    end
    if (state_q == S_HOLD && buf_release)
      reuse_vld_d = !(wr_seen_q || set_wr_hit);
    if (!rst) begin
      reuse_vld_d = 1'b0;
      wr_seen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    reuse_vld_q <= reuse_vld_d;
    wr_seen_q   <= wr_seen_d;
  end
`else
  logic unused_set_wr;
  assign unused_set_wr = ^{set_wr, set_wr_set};
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pkt_d            = pkt_q;
    buf_ld           = 1'b0;
    req_ready        = 1'b0;
    rd_en            = 1'b0;
    rd_set           = '0;
    fifo_push_lookup = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pkt_d = mk_pkt(req_tag, req_set);
          if (hit) begin
            state_d = S_PUSH;
          end else begin
            rd_en   = 1'b1;
            rd_set  = req_set;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          buf_ld  = 1'b1;
          state_d = S_PUSH;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_PUSH: begin
        fifo_push_lookup = !fifo_full_lookup;
        if (!fifo_full_lookup) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (buf_release) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // reset drops any in-flight read and silences all outputs
    if (!rst) begin
      state_d          = S_IDLE;
      cnt_d            = '0;
      pkt_d            = '0;
      buf_ld           = 1'b0;
      req_ready        = 1'b0;
      rd_en            = 1'b0;
      rd_set           = '0;
      fifo_push_lookup = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    pkt_q   <= pkt_d;
  end

  assign fifo_lookup_in = pkt_q;

  llc_set_buf_regs u_buf (
    .clk      (clk),
    .clr      (!rst),
    .ld       (buf_ld),
    .tags_i   (rd_tags),
    .states_i (rd_states),
    .evict_i  (rd_evict_way),
    .tags_o   (tags_buf),
    .states_o (states_buf),
    .evict_o  (evict_way_buf)
  );

endmodule

// File: tb/tb_llc_set_loader.sv
// Directed scoreboard bench for llc_set_loader with a delayed SRAM model.
// Reuse expectations follow LLC_SET_REUSE_EN when it is defined.
`timescale 1ns/1ps
module tb_llc_set_loader;
  import llc_set_loader_pkg::*;

  parameter int RD_LAT = 1;
`ifdef LLC_SET_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  llc_set_t req_set;
  llc_tag_t req_tag;
  logic rd_en;
  llc_set_t rd_set;
  llc_tag_arr_t rd_tags;
  llc_state_arr_t rd_states;
  llc_way_t rd_evict_way;
  llc_tag_arr_t tags_buf;
  llc_state_arr_t states_buf;
  llc_way_t evict_way_buf;
  logic fifo_full_lookup, fifo_push_lookup;
  fifo_mem_lookup_packet fifo_lookup_in;
  logic buf_release, set_wr;
  llc_set_t set_wr_set;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    fifo_mem_lookup_packet pkt;
    llc_tag_arr_t tags;
    llc_state_arr_t states;
    llc_way_t evict;
    int acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  llc_set_loader #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag),
    .rd_en(rd_en), .rd_set(rd_set),
    .rd_tags(rd_tags), .rd_states(rd_states),
    .rd_evict_way(rd_evict_way),
    .tags_buf(tags_buf), .states_buf(states_buf),
    .evict_way_buf(evict_way_buf),
    .fifo_full_lookup(fifo_full_lookup),
    .fifo_push_lookup(fifo_push_lookup),
    .fifo_lookup_in(fifo_lookup_in),
    .buf_release(buf_release),
    .set_wr(set_wr), .set_wr_set(set_wr_set)
  );

  function automatic llc_tag_arr_t m_tags(input llc_set_t s);
    llc_tag_arr_t r;
    for (int w = 0; w < LLC_WAYS; w++)
      r[w] = llc_tag_t'(12'h100 + int'(s) * 16 + w);
    return r;
  endfunction

  function automatic llc_state_arr_t m_states(input llc_set_t s);
    llc_state_arr_t r;
    for (int w = 0; w < LLC_WAYS; w++)
      r[w] = (s == 8'd9) ? INVALID :
             llc_state_t'(3'((int'(s) + w) % 4 + 1));
    return r;
  endfunction

  function automatic llc_way_t m_evict(input llc_set_t s);
    llc_way_t r;
    r = (s == 8'd9) ? 2'd2 : (s[1:0] ^ 2'd1);
    return r;
  endfunction

  // SRAM model: data valid exactly RD_LAT cycles after rd_en, junk otherwise
  logic     vpipe [RD_LAT];
  llc_set_t spipe [RD_LAT];
  always @(posedge clk) begin
    vpipe[0] <= rd_en;
    spipe[0] <= rd_set;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      spipe[i] <= spipe[i-1];
    end
  end
  always_comb begin
    rd_tags      = {LLC_WAYS{12'hEEE}};
    rd_states    = {LLC_WAYS{MODIFIED}};
    rd_evict_way = 2'd3;
    if (vpipe[RD_LAT-1] === 1'b1) begin
      rd_tags      = m_tags(spipe[RD_LAT-1]);
      rd_states    = m_states(spipe[RD_LAT-1]);
      rd_evict_way = m_evict(spipe[RD_LAT-1]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input llc_set_t s, input llc_tag_t t,
                        input bit exp_rd, input bit wr);
    exp_t e;
    req_valid = 1'b1;
    req_set = s;
    req_tag = t;
    set_wr = wr;
    set_wr_set = s;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    chk("rd_en", rd_en, exp_rd);
    if (exp_rd) chk("rd_set", rd_set, s);
    e.pkt = mk_pkt(t, s);
    e.tags = m_tags(s);
    e.states = m_states(s);
    e.evict = m_evict(s);
    e.acc = cyc;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    set_wr = 1'b0;
  endtask

  task automatic expect_push(input int delay);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_push_lookup === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("push_seen", seen, 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk("push_lat", cyc - e.acc, delay);
      chk("pkt", fifo_lookup_in, e.pkt);
      chk("tags_buf", tags_buf, e.tags);
      chk("states_buf", states_buf, e.states);
      chk("evict_buf", evict_way_buf, e.evict);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    step();
  endtask

  task automatic do_release();
    buf_release = 1'b1;
    @(negedge clk);
    chk("hold_ready", req_ready, 0);
    step();
    buf_release = 1'b0;
    @(negedge clk);
    chk("ready_after_rel", req_ready, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int pushes;
    rst = 1'b0;
    req_valid = 1'b0;
    req_set = '0;
    req_tag = '0;
    fifo_full_lookup = 1'b0;
    buf_release = 1'b0;
    set_wr = 1'b0;
    set_wr_set = '0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_push", fifo_push_lookup, 0);
    chk("rst_tags", tags_buf, 0);
    chk("rst_states", states_buf, 0);
    chk("rst_evict", evict_way_buf, 0);
    chk("rst_pkt", fifo_lookup_in, 0);
    step();

    // basic read of set 5
    do_req(8'd5, 12'h03A, 1'b1, 1'b0);
    expect_push(RD_LAT + 1);
    do_release();

    // FIFO full stall with early release pulses that must be ignored
    fifo_full_lookup = 1'b1;
    do_req(8'd3, 12'h111, 1'b1, 1'b0);
    pushes = 0;
    for (int i = 1; i <= RD_LAT + 4; i++) begin
      buf_release = (i == 1) || (i == RD_LAT + 2);
      @(negedge clk);
      if (fifo_push_lookup !== 1'b0) pushes++;
      step();
    end
    buf_release = 1'b0;
    fifo_full_lookup = 1'b0;
    chk("stall_no_push", pushes, 0);
    expect_push(RD_LAT + 5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_stays", req_ready, 0);
      step();
    end
    do_release();

    // reset while waiting on the SRAM
    do_req(8'd4, 12'h0AA, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("wrst_ready", req_ready, 1);
    chk("wrst_push", fifo_push_lookup, 0);
    pushes = 0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      step();
      @(negedge clk);
      if (fifo_push_lookup !== 1'b0) pushes++;
    end
    chk("wrst_no_push", pushes, 0);
    chk("wrst_tags", tags_buf, 0);
    chk("wrst_evict", evict_way_buf, 0);
    step();

    // same-set reuse and its invalidation
    do_req(8'd7, 12'h070, 1'b1, 1'b0);
    expect_push(RD_LAT + 1);
    do_release();
    do_req(8'd7, 12'h071, !REUSE, 1'b0);
    expect_push(REUSE ? 1 : RD_LAT + 1);
    do_release();
    set_wr = 1'b1;
    set_wr_set = 8'd7;
    step();
    set_wr = 1'b0;
    do_req(8'd7, 12'h072, 1'b1, 1'b0);
    expect_push(RD_LAT + 1);
    do_release();
    do_req(8'd7, 12'h073, !REUSE, 1'b0);
    expect_push(REUSE ? 1 : RD_LAT + 1);
    do_release();
    do_req(8'd7, 12'h074, 1'b1, 1'b1);
    expect_push(RD_LAT + 1);
    do_release();
    do_req(8'd8, 12'h080, 1'b1, 1'b0);
    expect_push(RD_LAT + 1);
    do_release();

    // all-INVALID set with evict pointer 2, held through HOLD
    do_req(8'd9, 12'h099, 1'b1, 1'b0);
    expect_push(RD_LAT + 1);
    repeat (3) step();
    @(negedge clk);
    chk("hold_states", states_buf, m_states(8'd9));
    chk("hold_evict", evict_way_buf, 2);
    chk("hold_tags", tags_buf, m_tags(8'd9));
    step();
    do_release();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
